// File: rtl/nco_link_pkg.sv
// nco_link_pkg: constants and receiver state type shared by the phase-address link endpoints
package nco_link_pkg;
  localparam int CW = 2;
  localparam int NCHUNK = 6;
  localparam int AW = CW * NCHUNK;
  localparam int FRAME_LEN = NCHUNK + 1;
  localparam int SLOTW = $clog2(NCHUNK);
  typedef enum logic [1:0] {IDLE, SHIFT, EXPECT} rx_state_t;
endpackage

// File: rtl/chunk_deser.sv
// chunk_deser: slot-indexed chunk capture; word presents the full address combinationally in the last slot
module chunk_deser
  import nco_link_pkg::*;
(
  input  logic          clk,
  input  logic          En,
  input  logic          start,
  input  logic          shift,
  input  logic [CW-1:0] din,
  output logic [AW-1:0] word,
  output logic          done
);
  logic [SLOTW-1:0] slot_q, slot_d;
  logic [AW-CW-1:0] sr_q, sr_d;
  always_comb begin
    done = shift && slot_q == SLOTW'(NCHUNK - 1);
    slot_d = (start || done) ? '0 : shift ? SLOTW'(slot_q + 1'b1) : slot_q;
    sr_d = start ? '0 : sr_q;
    if (shift && !done) sr_d[CW*slot_q +: CW] = din;
    word = {din, sr_q};
  end
  always_ff @(posedge clk)
    if (!En) begin
      slot_q <= '0;
      sr_q <= '0;
    end else begin
      slot_q <= slot_d;
      sr_q <= sr_d;
    end
endmodule

// File: rtl/phase_word_receiver.sv
// phase_word_receiver: frames the 2-bit serial phase link, pairs each address with its sign, counts framing errors
module phase_word_receiver
  import nco_link_pkg::*;
#(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            En,
  input  logic            Vld,
  input  logic [CW-1:0]   Ain,
  input  logic            ISin,
  output logic            Dvld,
  output logic [AW-1:0]   Addr,
  output logic            Sign,
  output logic            FrmErr,
  output logic [ERRW-1:0] ErrCnt
);
  rx_state_t state_q, state_d;
  logic pend_q, pend_d, dvld_q, dvld_d, sign_q, sign_d, frm_err_q, frm_err_d;
  logic [AW-1:0] addr_q, addr_d, word;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic shift, done, err;
  chunk_deser u_deser (
    .clk(clk), .En(En), .start(Vld), .shift(shift), .din(Ain), .word(word), .done(done)
  );
  always_comb begin
    shift = state_q == SHIFT && !Vld;
    err = Vld ? state_q == SHIFT : state_q == EXPECT;
    state_d = Vld ? SHIFT : state_q == EXPECT ? IDLE : done ? EXPECT : state_q;
    pend_d = Vld ? ISin : pend_q;
    dvld_d = done;
    addr_d = done ? word : addr_q;
    sign_d = done ? pend_q : sign_q;
    frm_err_d = err;
    err_cnt_d = (err && err_cnt_q != '1) ? ERRW'(err_cnt_q + 1'b1) : err_cnt_q;
  end
  always_ff @(posedge clk)
    if (!En) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      dvld_q <= 1'b0;
      addr_q <= '0;
      sign_q <= 1'b0;
      frm_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      dvld_q <= dvld_d;
      addr_q <= addr_d;
      sign_q <= sign_d;
      frm_err_q <= frm_err_d;
      err_cnt_q <= err_cnt_d;
    end
  assign Dvld = dvld_q;
  assign Addr = addr_q;
  assign Sign = sign_q;
  assign FrmErr = frm_err_q;
  assign ErrCnt = err_cnt_q;
endmodule

// File: tb/tb_phase_word_receiver.sv
// tb_phase_word_receiver: randomized scenario tests against a frame-level reference model
module tb_phase_word_receiver;
  logic clk = 0, En = 0, Vld = 0, ISin = 0;
  logic [1:0] Ain = 2'b00;
  logic Dvld, Sign, FrmErr;
  logic [11:0] Addr;
  logic [7:0] ErrCnt;
  int checks = 0, errors = 0;
  phase_word_receiver dut (
    .clk(clk), .En(En), .Vld(Vld), .Ain(Ain), .ISin(ISin),
    .Dvld(Dvld), .Addr(Addr), .Sign(Sign), .FrmErr(FrmErr), .ErrCnt(ErrCnt)
  );
  always #5 clk = ~clk;
  task automatic tick(input logic v, input logic s, input logic [1:0] a);
    Vld = v;
    ISin = s;
    Ain = a;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    En = 0;
    tick(0, 0, 2'bxx);
    tick(0, 0, 2'bxx);
    En = 1;
  endtask
  task automatic send_chunks(input logic [11:0] w);
    for (int i = 0; i < 6; i++) tick(0, 1'($urandom), 2'(w >> (2 * i)));
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({Dvld, Addr, Sign, FrmErr, ErrCnt} !== 23'd0)
      begin errors++; $display("FAIL reset: got %h want 0", {Dvld, Addr, Sign, FrmErr, ErrCnt}); end
  endtask
  task automatic test_single();
    logic [1:0] ch [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
    do_reset();
    tick(1, 1, 2'bxx);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, ch[i]);
      checks++;
      if (Dvld !== (i == 5)) begin errors++; $display("FAIL single_dvld slot %0d: got %b want %b", i, Dvld, i == 5); end
    end
    checks++;
    if (Addr !== 12'h939) begin errors++; $display("FAIL single_addr: got %h want 939", Addr); end
    checks++;
    if (Sign !== 1'b1) begin errors++; $display("FAIL single_sign: got %b want 1", Sign); end
    checks++;
    if (FrmErr !== 1'b0) begin errors++; $display("FAIL single_frmerr: got %b want 0", FrmErr); end
  endtask
  task automatic test_stream();
    logic [11:0] w;
    logic [1:0] a;
    logic s;
    int cyc = 0, last = 0, nstb = 0;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      s = 1'($urandom);
      w = 0;
      tick(1, s, 2'bxx);
      cyc++;
      checks++;
      if (Dvld !== 1'b0) begin errors++; $display("FAIL stream_vld_cycle frame %0d: Dvld got %b want 0", n, Dvld); end
      for (int i = 0; i < 6; i++) begin
        a = 2'($urandom);
        w += 12'(a) << (2 * i);
        tick(0, 1'($urandom), a);
        cyc++;
        checks++;
        if (Dvld !== (i == 5)) begin errors++; $display("FAIL stream_dvld frame %0d slot %0d: got %b want %b", n, i, Dvld, i == 5); end
        if (Dvld === 1'b1) begin
          nstb++;
          checks++;
          if (Addr !== w) begin errors++; $display("FAIL stream_addr frame %0d: got %h want %h", n, Addr, w); end
          checks++;
          if (Sign !== s) begin errors++; $display("FAIL stream_sign frame %0d: got %b want %b", n, Sign, s); end
          if (n > 0) begin
            checks++;
            if (cyc - last != 7) begin errors++; $display("FAIL stream_spacing frame %0d: got %0d want 7", n, cyc - last); end
          end
          last = cyc;
        end
      end
    end
    tick(1, 0, 2'bxx);
    checks++;
    if (nstb != 10) begin errors++; $display("FAIL stream_count: got %0d want 10", nstb); end
    checks++;
    if (ErrCnt !== 8'd0) begin errors++; $display("FAIL stream_errcnt: got %0d want 0", ErrCnt); end
  endtask
  task automatic test_early_vld();
    int nstb = 0;
    do_reset();
    tick(1, 1, 2'bxx);
    for (int i = 0; i < 3; i++) tick(0, 1, 2'($urandom));
    tick(1, 0, 2'bxx);
    checks++;
    if (FrmErr !== 1'b1) begin errors++; $display("FAIL early_frmerr: got %b want 1", FrmErr); end
    checks++;
    if (ErrCnt !== 8'd1) begin errors++; $display("FAIL early_errcnt: got %0d want 1", ErrCnt); end
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 2'b11);
      nstb += int'(Dvld);
      checks++;
      if (FrmErr !== 1'b0) begin errors++; $display("FAIL early_frmerr_after slot %0d: got %b want 0", i, FrmErr); end
    end
    checks++;
    if (nstb != 1 || Dvld !== 1'b1) begin errors++; $display("FAIL early_strobes: got %0d (Dvld %b) want 1 (1)", nstb, Dvld); end
    checks++;
    if (Addr !== 12'hFFF || Sign !== 1'b0) begin errors++; $display("FAIL early_word: got %h/%b want fff/0", Addr, Sign); end
  endtask
  task automatic test_missing_vld();
    logic [11:0] w = 12'($urandom);
    logic s = 1'($urandom);
    int nerr = 0, nstb = 0;
    do_reset();
    tick(1, s, 2'bxx);
    send_chunks(w);
    checks++;
    if (Dvld !== 1'b1 || Addr !== w) begin errors++; $display("FAIL missing_word: got %b/%h want 1/%h", Dvld, Addr, w); end
    for (int i = 0; i < 10; i++) begin
      tick(0, 1'($urandom), 2'($urandom));
      nerr += int'(FrmErr);
      nstb += int'(Dvld);
      if (i == 0) begin
        checks++;
        if (FrmErr !== 1'b1) begin errors++; $display("FAIL missing_expect_pulse: got %b want 1", FrmErr); end
      end
    end
    checks++;
    if (nerr != 1 || nstb != 0) begin errors++; $display("FAIL missing_counts: errs %0d strobes %0d want 1 0", nerr, nstb); end
    checks++;
    if (ErrCnt !== 8'd1) begin errors++; $display("FAIL missing_errcnt: got %0d want 1", ErrCnt); end
    w = 12'($urandom);
    s = ~s;
    tick(1, s, 2'bxx);
    checks++;
    if (FrmErr !== 1'b0) begin errors++; $display("FAIL missing_restart_err: got %b want 0", FrmErr); end
    send_chunks(w);
    checks++;
    if (Dvld !== 1'b1 || Addr !== w || Sign !== s) begin errors++; $display("FAIL missing_restart_word: got %b/%h/%b want 1/%h/%b", Dvld, Addr, Sign, w, s); end
  endtask
  task automatic test_reset_mid();
    int nstb = 0;
    do_reset();
    tick(1, 1, 2'bxx);
    send_chunks(12'h5A5);
    tick(1, 1, 2'bxx);
    tick(0, 0, 2'b10);
    tick(0, 0, 2'b01);
    En = 0;
    tick(0, 0, 2'b11);
    checks++;
    if ({Dvld, Addr, Sign, FrmErr, ErrCnt} !== 23'd0)
      begin errors++; $display("FAIL midreset_outputs: got %h want 0", {Dvld, Addr, Sign, FrmErr, ErrCnt}); end
    En = 1;
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 2'($urandom));
      nstb += int'(Dvld) + int'(FrmErr);
    end
    checks++;
    if (nstb != 0) begin errors++; $display("FAIL midreset_quiet: got %0d events want 0", nstb); end
    tick(1, 0, 2'bxx);
    for (int i = 0; i < 5; i++) tick(0, 1, 2'b00);
    tick(0, 1, 2'b11);
    checks++;
    if (Dvld !== 1'b1 || Addr !== 12'hC00 || Sign !== 1'b0) begin errors++; $display("FAIL midreset_frame: got %b/%h/%b want 1/c00/0", Dvld, Addr, Sign); end
  endtask
  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    tick(1, 0, 2'bxx);
    for (int i = 1; i <= 300; i++) begin
      tick(1, 0, 2'bxx);
      exp_cnt = i > 255 ? 255 : i;
      checks++;
      if (FrmErr !== 1'b1 || ErrCnt !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_err %0d: got %b/%0d want 1/%0d", i, FrmErr, ErrCnt, exp_cnt); end
    end
    tick(0, 0, 2'b00);
    checks++;
    if (ErrCnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", ErrCnt); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_stream();
    test_early_vld();
    test_missing_vld();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_word_receiver.md
Name: phase_word_receiver

Overview:
- Receive end of the 2-bit serial phase-address link driven by the NCO phase accumulator.
- Tracks the 7-cycle frame (one Vld slot, then six 2-bit address slots, LSB chunk first) and reassembles the 12-bit quadrant-folded address.
- Pairs the address with the sign flag that accompanies its frame and presents {Sign, Addr} with a one-cycle strobe to the downstream sine LUT/output stage.
- Detects framing errors and resynchronises.

Parameters:
- CW, 2, chunk width in bits.
- NCHUNK, 6, chunks per frame. Address width AW = CW*NCHUNK = 12.
- ERRW, 8, width of the saturating frame-error counter.

Ports:
- clk  input  1  system clock, rising edge.
- En  input  1  synchronous active-low reset; low = clear all state.
- Vld  input  1  frame marker from the transmitter; high for one cycle per frame.
- Ain  input  CW  serial address chunk; valid only in slots 0..5 after Vld.
- ISin  input  1  invert-sign flag; sampled only in the Vld cycle.
- Dvld  output  1  one-cycle strobe: Addr/Sign updated.
- Addr  output  AW  reassembled address; held between strobes.
- Sign  output  1  sign paired with Addr; held between strobes.
- FrmErr  output  1  one-cycle pulse on framing error.
- ErrCnt  output  ERRW  saturating count of framing errors.

Behaviour:
- All outputs and state are updated only on rising clk. Reset is synchronous, En=0 sampled at a clk edge.
- Reset values: Dvld=0, Addr=0, Sign=0, FrmErr=0, ErrCnt=0, FSM=IDLE, slot=0, shift register=0, pend_sign=0.
- Reset applied mid-frame discards the partial frame. No strobe is produced for it.
- FSM states:
  - IDLE: wait for Vld.
  - SHIFT: slot counter 0..5.
  - EXPECT: the cycle in which the next Vld is due.
- IDLE:
  - Vld=1: pend_sign<=ISin, slot<=0, go SHIFT.
  - Ain is ignored.
- SHIFT, slot s, Vld=0:
  - Capture Ain into bits [CW*s+1 : CW*s].
  - s<5: slot<=s+1.
  - s=5: Addr<={Ain, captured[9:0]}, Sign<=pend_sign, Dvld<=1 (visible the next cycle), go EXPECT.
- SHIFT with Vld=1 (early marker):
  - FrmErr pulse, ErrCnt+1.
  - Discard the partial word. Treat this Vld as a fresh frame start: pend_sign<=ISin, slot<=0, stay SHIFT.
- EXPECT:
  - Vld=1: normal back-to-back frame. pend_sign<=ISin, slot<=0, go SHIFT. No error.
  - Vld=0: FrmErr pulse, ErrCnt+1, go IDLE.
- Latency: Dvld is asserted in the cycle after slot 5, which coincides with the next Vld in a continuous stream.
- Throughput: one word per 7 cycles.
- Sign pairing: the ISin sampled in a frame's Vld cycle belongs to the address carried in the six slots that follow it. It must not be paired with the previous frame's address.
- ErrCnt saturates at 2^ERRW-1 and never wraps. FrmErr still pulses when ErrCnt is saturated.
- Dvld and FrmErr are never high in the same cycle.
- Addr and Sign change only together with Dvld.
- X/undefined on Ain outside slots 0..5 must not propagate into Addr.

Decomposition:
- Shared package `nco_link_pkg` holds:
  - CW, NCHUNK, AW, FRAME_LEN=7;
  - the receiver FSM state enum {IDLE, SHIFT, EXPECT}.
- The transmitter and any bus monitor import the same constants.
- One natural sub-module: `chunk_deser`, the slot-indexed CW-bit shift/capture register with a done flag. The FSM, sign pairing and error counter stay in the top.

Test Plan:
- Single frame: reset, then Vld=1 with ISin=1, then Ain=01,10,11,00,01,10 → next cycle Dvld=1, Addr=0x939, Sign=1, FrmErr=0.
- Continuous stream: 10 back-to-back 7-cycle frames with random Ain/ISin → 10 strobes exactly 7 cycles apart. Each Addr/Sign matches the scoreboard, which pairs ISin of frame N with the chunks of frame N. ErrCnt=0.
- Early Vld: Vld at cycle 0, then Vld again at slot 3 with ISin=0, then six chunks of 11 → FrmErr pulse at the early Vld, ErrCnt=1, then a single strobe with Addr=0xFFF, Sign=0.
- Missing Vld: complete frame, then Vld held low for 10 cycles → Dvld once, FrmErr pulse in the EXPECT cycle, ErrCnt=1, FSM idle. The next Vld restarts cleanly.
- Reset mid-frame: En=0 for one cycle at slot 2 → all outputs 0, no strobe. A following full frame with Ain=00 x5 then 11 → Addr=0xC00.
- Saturation: force 300 early-Vld errors → ErrCnt=255 and holds there, with FrmErr still pulsing on each error.
